// File: rtl/mac_array_ctrl.sv
// Sequencer for the 1D MAC column array: one job per start pulse runs key load,
// a one-cycle bubble, query execute and a pipeline drain, then pulses done.
module mac_array_ctrl #(
  parameter int col    = 8,
  parameter int addr_w = 4,
  parameter int cnt_w  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_w-1:0]  load_len,
  input  logic [cnt_w-1:0]  exec_len,
  input  logic [addr_w-1:0] key_base,
  input  logic [addr_w-1:0] query_base,
  input  logic              fifo_ready,
  output logic              mem_cen,
  output logic [addr_w-1:0] mem_addr,
  output logic [1:0]        inst,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, EXEC, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [cnt_w-1:0]   cnt, cnt_nxt;
  logic [cnt_w-1:0]   load_len_q, exec_len_q;
  logic [addr_w-1:0]  key_q, query_q, cnt_a;
  logic               accept;

  assign accept = (state == IDLE) && start && fifo_ready;
  assign cnt_a  = addr_w'(cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      load_len_q <= '0;
      exec_len_q <= '0;
      key_q      <= '0;
      query_q    <= '0;
      inst       <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Operand data arrives one cycle after the read, so inst trails the read phase.
      inst  <= {state == EXEC, state == LOAD};
      if (accept) begin
        load_len_q <= load_len;
        exec_len_q <= exec_len;
        key_q      <= key_base;
        query_q    <= query_base;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_cen   = 1'b1;
    mem_addr  = '0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          if (load_len != '0)      state_nxt = LOAD;
          else if (exec_len != '0) state_nxt = EXEC;
          else                     state_nxt = DONE;
        end
      end
      LOAD: begin
        mem_cen  = 1'b0;
        mem_addr = key_q + cnt_a;
        if (cnt == load_len_q - cnt_w'(1)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + cnt_w'(1);
        end
      end
      GAP: begin
        cnt_nxt   = '0;
        state_nxt = (exec_len_q != '0) ? EXEC : DRAIN;
      end
      EXEC: begin
        mem_cen  = 1'b0;
        mem_addr = query_q + cnt_a;
        if (cnt == exec_len_q - cnt_w'(1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + cnt_w'(1);
        end
      end
      DRAIN: begin
        // Last beat walks the column chain, plus two cycles of fifo_wr delay.
        if (cnt == cnt_w'(col + 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + cnt_w'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: table jobs, corner sequences and
// random jobs compared against a phase-list model of a whole job.
module tb_mac_array_ctrl;
  localparam int COL = 8, AW = 4, CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] load_len = '0, exec_len = '0;
  logic [AW-1:0] key_base = '0, query_base = '0;
  logic          fifo_ready = 1'b1;
  logic          mem_cen;
  logic [AW-1:0] mem_addr;
  logic [1:0]    inst;
  logic          busy, done;

  int n_vec = 0, n_bad = 0;

  mac_array_ctrl #(.col(COL), .addr_w(AW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .exec_len(exec_len), .key_base(key_base), .query_base(query_base),
    .fifo_ready(fifo_ready), .mem_cen(mem_cen), .mem_addr(mem_addr),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cen;
    logic [AW-1:0] addr;
    logic [1:0]    inst;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    int l, e, kb, qb;
    int done_t;  // cycle of the done pulse, counted from the start cycle
  } vec_t;

  // phase codes used by the model
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_EXEC = 2, PH_WAIT = 3, PH_DONE = 4;

  task automatic check(input string name, input int t, input obs_t e);
    n_vec++;
    if (mem_cen !== e.cen || mem_addr !== e.addr || inst !== e.inst ||
        busy !== e.busy || done !== e.done) begin
      n_bad++;
      $display("FAIL %s t=%0d got cen=%b addr=%0d inst=%b busy=%b done=%b want cen=%b addr=%0d inst=%b busy=%b done=%b",
               name, t, mem_cen, mem_addr, inst, busy, done, e.cen, e.addr, e.inst, e.busy, e.done);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o.cen = 1'b1; o.addr = '0; o.inst = 2'b00; o.busy = 1'b0; o.done = 1'b0;
    return o;
  endfunction

  // Model: list the phase of every cycle of the job, then derive outputs.
  // inst in a cycle reflects the read phase of the cycle before.
  task automatic run_job(input string name, input int l, input int e, input int kb,
                         input int qb, input bit disturb, input int exp_done_t);
    int   ph[$];
    int   idx[$];
    obs_t o;
    int   done_at, n_done, dt;
    ph.push_back(PH_IDLE); idx.push_back(0);
    if (l == 0 && e == 0) begin
      ph.push_back(PH_DONE); idx.push_back(0);
    end else begin
      for (int i = 0; i < l; i++) begin ph.push_back(PH_LOAD); idx.push_back(i); end
      if (l > 0) begin ph.push_back(PH_WAIT); idx.push_back(0); end
      for (int i = 0; i < e; i++) begin ph.push_back(PH_EXEC); idx.push_back(i); end
      for (int i = 0; i < COL + 2; i++) begin ph.push_back(PH_WAIT); idx.push_back(0); end
      ph.push_back(PH_DONE); idx.push_back(0);
    end
    ph.push_back(PH_IDLE); idx.push_back(0);
    ph.push_back(PH_IDLE); idx.push_back(0);
    dt = disturb ? $urandom_range(ph.size() - 3, 1) : -1;
    done_at = -1; n_done = 0;
    for (int t = 0; t < ph.size(); t++) begin
      @(negedge clk);
      o.cen  = !(ph[t] == PH_LOAD || ph[t] == PH_EXEC);
      o.addr = (ph[t] == PH_LOAD) ? AW'(kb + idx[t]) :
               (ph[t] == PH_EXEC) ? AW'(qb + idx[t]) : '0;
      o.inst = (t == 0) ? 2'b00 : {ph[t-1] == PH_EXEC, ph[t-1] == PH_LOAD};
      o.busy = (ph[t] != PH_IDLE);
      o.done = (ph[t] == PH_DONE);
      check(name, t, o);
      if (done === 1'b1) begin n_done++; done_at = t; end
      start = 1'b0;
      if (t == 0) begin
        start = 1'b1;
        load_len = CW'(l); exec_len = CW'(e); key_base = AW'(kb); query_base = AW'(qb);
      end else if (t == dt) begin
        // mid-job start with different config must change nothing
        start = 1'b1;
        load_len = CW'($urandom); exec_len = CW'($urandom);
        key_base = AW'($urandom); query_base = AW'($urandom);
      end
    end
    start = 1'b0;
    check_int({name, " done_count"}, n_done, 1);
    if (exp_done_t >= 0) check_int({name, " done_cycle"}, done_at, exp_done_t);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{l: 9, e: 8, kb: 0,  qb: 9, done_t: 29};
    tbl[1] = '{l: 0, e: 3, kb: 5,  qb: 2, done_t: 14};
    tbl[2] = '{l: 0, e: 0, kb: 3,  qb: 4, done_t: 1};
    tbl[3] = '{l: 4, e: 2, kb: 14, qb: 7, done_t: 18};
    tbl[4] = '{l: 4, e: 0, kb: 14, qb: 0, done_t: 16};
    tbl[5] = '{l: 1, e: 1, kb: 15, qb: 15, done_t: 14};

    // reset state, checked while reset is held
    repeat (2) @(negedge clk);
    check("reset_hold", 0, idle_obs());
    reset = 1'b1;
    @(negedge clk);
    check("reset_release", 0, idle_obs());

    foreach (tbl[i])
      run_job($sformatf("tbl%0d", i), tbl[i].l, tbl[i].e, tbl[i].kb, tbl[i].qb, 1'b0, tbl[i].done_t);

    // start dropped while fifo_ready is low
    fifo_ready = 1'b0;
    start = 1'b1; load_len = 5'd3; exec_len = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("fifo_block", t, idle_obs());
    end
    fifo_ready = 1'b1;
    run_job("fifo_retry", 9, 8, 0, 9, 1'b0, 29);

    // start pulsed during the job
    run_job("disturb", 9, 8, 0, 9, 1'b1, 29);

    // reset in LOAD cycle 4 clears outputs before the next clock edge
    @(negedge clk);
    start = 1'b1; load_len = 5'd9; exec_len = 5'd8; key_base = 4'd0; query_base = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", 4, idle_obs());
    @(negedge clk);
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("post_reset_idle", t, idle_obs());
    end
    run_job("post_reset_job", 9, 8, 0, 9, 1'b0, 29);

    // random jobs against the model
    for (int k = 0; k < 25; k++) begin
      int rl, re;
      rl = $urandom_range(20, 0);
      re = $urandom_range(20, 0);
      if (k % 7 == 0) rl = 0;
      if (k % 5 == 0) re = 0;
      fifo_ready = 1'b1;
      run_job($sformatf("rand%0d", k), rl, re, $urandom_range(15, 0), $urandom_range(15, 0),
              1'($urandom_range(1, 0)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
